// File: rtl/controle_retorno.sv
// Call/return sequencer for the return-address stack: turns CALL/RET requests into
// push/pop handshakes, tracks stack depth, flags misuse and redirects fetch.
module controle_retorno #(
    parameter int LARGURA      = 11,
    parameter int PROFUNDIDADE = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_req,
    input  logic                  ret_req,
    input  logic [LARGURA-1:0]    pc_atual,
    input  logic [LARGURA-1:0]    pc_destino,
    input  logic [LARGURA-1:0]    pilha_topo,
    output logic [LARGURA-1:0]    pilha_dado,
    output logic                  pilha_push,
    output logic                  pilha_pop,
    output logic [LARGURA-1:0]    pc_prox,
    output logic                  pc_load,
    output logic                  ocupado,
    output logic [PROFUNDIDADE:0] nivel,
    output logic                  erro_overflow,
    output logic                  erro_underflow,
    output logic                  erro_conflito
);

    localparam logic [PROFUNDIDADE:0] NIVEL_MAX  = {1'b1, {PROFUNDIDADE{1'b0}}};
    localparam logic [PROFUNDIDADE:0] NIVEL_ZERO = '0;
    localparam logic [PROFUNDIDADE:0] NIVEL_UM   = {{PROFUNDIDADE{1'b0}}, 1'b1};
    localparam logic [LARGURA-1:0]    PC_UM      = {{(LARGURA-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        OCIOSO,
        EMPILHA,
        DESEMPILHA,
        ESPERA_TOPO,
        RETORNA
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [LARGURA-1:0]      pilha_dado_q, pilha_dado_d;
    logic [LARGURA-1:0]      pc_prox_q, pc_prox_d;
    logic [PROFUNDIDADE:0]   nivel_q, nivel_d;
    logic                    erro_overflow_q, erro_overflow_d;
    logic                    erro_underflow_q, erro_underflow_d;
    logic                    erro_conflito_q, erro_conflito_d;
    logic                    push_c, pop_c, load_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            pilha_dado_q     <= '0;
            pc_prox_q        <= '0;
            nivel_q          <= '0;
            erro_overflow_q  <= 1'b0;
            erro_underflow_q <= 1'b0;
            erro_conflito_q  <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            pilha_dado_q     <= pilha_dado_d;
            pc_prox_q        <= pc_prox_d;
            nivel_q          <= nivel_d;
            erro_overflow_q  <= erro_overflow_d;
            erro_underflow_q <= erro_underflow_d;
            erro_conflito_q  <= erro_conflito_d;
        end
    end

    // Requests are only decoded in OCIOSO; conflict takes priority over range errors.
    always_comb begin
        estado_d         = estado_q;
        pilha_dado_d     = pilha_dado_q;
        pc_prox_d        = pc_prox_q;
        nivel_d          = nivel_q;
        erro_overflow_d  = erro_overflow_q;
        erro_underflow_d = erro_underflow_q;
        erro_conflito_d  = 1'b0;
        push_c           = 1'b0;
        pop_c            = 1'b0;
        load_c           = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (call_req && ret_req) begin
                    erro_conflito_d = 1'b1;
                end else if (call_req) begin
                    if (nivel_q == NIVEL_MAX) begin
                        erro_overflow_d = 1'b1;
                    end else begin
                        pilha_dado_d = pc_atual + PC_UM;
                        pc_prox_d    = pc_destino;
                        estado_d     = EMPILHA;
                    end
                end else if (ret_req) begin
                    if (nivel_q == NIVEL_ZERO) begin
                        erro_underflow_d = 1'b1;
                    end else begin
                        estado_d = DESEMPILHA;
                    end
                end
            end
            EMPILHA: begin
                push_c   = 1'b1;
                load_c   = 1'b1;
                nivel_d  = nivel_q + NIVEL_UM;
                estado_d = OCIOSO;
            end
            DESEMPILHA: begin
                pop_c    = 1'b1;
                nivel_d  = nivel_q - NIVEL_UM;
                estado_d = ESPERA_TOPO;
            end
            ESPERA_TOPO: begin
                // The stack presents the popped entry one cycle after the pop strobe.
                pc_prox_d = pilha_topo;
                estado_d  = RETORNA;
            end
            RETORNA: begin
                load_c   = 1'b1;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign pilha_dado     = pilha_dado_q;
    assign pilha_push     = push_c;
    assign pilha_pop      = pop_c;
    assign pc_prox        = pc_prox_q;
    assign pc_load        = load_c;
    assign ocupado        = (estado_q != OCIOSO);
    assign nivel          = nivel_q;
    assign erro_overflow  = erro_overflow_q;
    assign erro_underflow = erro_underflow_q;
    assign erro_conflito  = erro_conflito_q;

endmodule

// File: tb/tb_controle_retorno.sv
// Randomized self-checking bench for controle_retorno, with a small LIFO stack model
// attached to the push/pop port and a transaction-level reference model.
module tb_controle_retorno;

    localparam int LARGURA = 11;
    localparam int PROF    = 2;
    localparam int CAP     = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                call_req, ret_req;
    logic [LARGURA-1:0]  pc_atual, pc_destino, pilha_topo;
    logic [LARGURA-1:0]  pilha_dado, pc_prox;
    logic                pilha_push, pilha_pop, pc_load, ocupado;
    logic [PROF:0]       nivel;
    logic                erro_overflow, erro_underflow, erro_conflito;

    int checks = 0;
    int errors = 0;

    logic [LARGURA-1:0]  ref_q[$];
    bit                  ref_ovf, ref_udf;

    controle_retorno #(.LARGURA(LARGURA), .PROFUNDIDADE(PROF)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
        .pc_atual(pc_atual), .pc_destino(pc_destino), .pilha_topo(pilha_topo),
        .pilha_dado(pilha_dado), .pilha_push(pilha_push), .pilha_pop(pilha_pop),
        .pc_prox(pc_prox), .pc_load(pc_load), .ocupado(ocupado), .nivel(nivel),
        .erro_overflow(erro_overflow), .erro_underflow(erro_underflow),
        .erro_conflito(erro_conflito)
    );

    always #5 clk = ~clk;

    // Stack device: registered top-of-stack output that shows the popped entry.
    logic [LARGURA-1:0] stk_mem [0:CAP-1];
    logic [2:0]         stk_sp;
    logic [1:0]         stk_wr_idx, stk_rd_idx;
    assign stk_wr_idx = stk_sp[1:0];
    assign stk_rd_idx = stk_sp[1:0] - 2'd1;

    always @(posedge clk) begin
        if (reset) begin
            stk_sp     <= 3'd0;
            pilha_topo <= '0;
        end else if (pilha_push && stk_sp < 3'd4) begin
            stk_mem[stk_wr_idx] <= pilha_dado;
            stk_sp              <= stk_sp + 3'd1;
        end else if (pilha_pop && stk_sp > 3'd0) begin
            pilha_topo <= stk_mem[stk_rd_idx];
            stk_sp     <= stk_sp - 3'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStrobes(input string tag, input bit push, input bit pop, input bit load,
                                input bit ocup, input bit conf);
        checkOutput({tag, ".push_pop_load_ocup_conf"},
                    {27'd0, pilha_push, pilha_pop, pc_load, ocupado, erro_conflito},
                    {27'd0, push, pop, load, ocup, conf});
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, ".ovf_udf"}, {30'd0, erro_overflow, erro_underflow}, {30'd0, ref_ovf, ref_udf});
        checkOutput({tag, ".nivel"}, 32'(nivel), ref_q.size());
    endtask

    // One request issued from idle, followed until the sequencer is idle again.
    task automatic applyStimulus(input string tag, input bit c, input bit r,
                                 input logic [LARGURA-1:0] pa, input logic [LARGURA-1:0] pd,
                                 input bit busy_call);
        int                 lvl;
        logic [LARGURA-1:0] exp_val;
        lvl        = ref_q.size();
        call_req   = c;
        ret_req    = r;
        pc_atual   = pa;
        pc_destino = pd;
        step();
        call_req = 1'b0;
        ret_req  = 1'b0;
        if (c && r) begin
            checkStrobes({tag, ".conf1"}, 0, 0, 0, 0, 1);
            step();
            checkStrobes({tag, ".conf2"}, 0, 0, 0, 0, 0);
            checkFlags(tag);
        end else if (c) begin
            if (lvl == CAP) begin
                ref_ovf = 1'b1;
                checkStrobes({tag, ".ovf"}, 0, 0, 0, 0, 0);
                checkFlags(tag);
            end else begin
                exp_val = LARGURA'((int'(pa) + 1) % (1 << LARGURA));
                checkStrobes({tag, ".call1"}, 1, 0, 1, 1, 0);
                checkOutput({tag, ".pilha_dado"}, 32'(pilha_dado), 32'(exp_val));
                checkOutput({tag, ".pc_prox"}, 32'(pc_prox), 32'(pd));
                step();
                ref_q.push_back(exp_val);
                checkStrobes({tag, ".call2"}, 0, 0, 0, 0, 0);
                checkFlags(tag);
            end
        end else if (r) begin
            if (lvl == 0) begin
                ref_udf = 1'b1;
                checkStrobes({tag, ".udf"}, 0, 0, 0, 0, 0);
                checkFlags(tag);
            end else begin
                exp_val = ref_q.pop_back();
                checkStrobes({tag, ".ret1"}, 0, 1, 0, 1, 0);
                if (busy_call) begin
                    call_req = 1'b1;
                    pc_atual = LARGURA'($urandom);
                end
                step();
                checkStrobes({tag, ".ret2"}, 0, 0, 0, 1, 0);
                step();
                checkStrobes({tag, ".ret3"}, 0, 0, 1, 1, 0);
                checkOutput({tag, ".pc_ret"}, 32'(pc_prox), 32'(exp_val));
                checkFlags(tag);
                step();
                call_req = 1'b0;
                checkStrobes({tag, ".ret4"}, 0, 0, 0, 0, 0);
                checkFlags(tag);
            end
        end else begin
            checkStrobes({tag, ".idle"}, 0, 0, 0, 0, 0);
            checkFlags(tag);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkStrobes(tag, 0, 0, 0, 0, 0);
        checkOutput({tag, ".pilha_dado"}, 32'(pilha_dado), 0);
        checkOutput({tag, ".pc_prox"}, 32'(pc_prox), 0);
        checkOutput({tag, ".nivel"}, 32'(nivel), 0);
        checkOutput({tag, ".ovf_udf"}, {30'd0, erro_overflow, erro_underflow}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        reset      = 1'b1;
        call_req   = 1'b0;
        ret_req    = 1'b0;
        pc_atual   = '0;
        pc_destino = '0;
        ref_ovf    = 1'b0;
        ref_udf    = 1'b0;
        step();
        step();
        checkResetState("reset_init");
        reset = 1'b0;
        step();

        applyStimulus("call_basic", 1, 0, 11'h010, 11'h200, 0);
        applyStimulus("ret_basic", 0, 1, 11'h000, 11'h000, 1);
        applyStimulus("underflow", 0, 1, 11'h000, 11'h000, 0);
        applyStimulus("call_after_udf", 1, 0, 11'h123, 11'h456, 0);
        applyStimulus("ret_after_udf", 0, 1, 11'h000, 11'h000, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus("overflow_seq", 1, 0, LARGURA'(11'h100 + i), LARGURA'(11'h300 + i), 0);
        for (int i = 0; i < 4; i++)
            applyStimulus("drain", 0, 1, 11'h000, 11'h000, 1);
        applyStimulus("conflict", 1, 1, 11'h055, 11'h0AA, 0);
        applyStimulus("wrap_call", 1, 0, 11'h7FF, 11'h3C3, 0);
        applyStimulus("wrap_ret", 0, 1, 11'h000, 11'h000, 1);

        // Reset held two cycles while a pop is in flight.
        applyStimulus("pre_reset_call", 1, 0, 11'h222, 11'h444, 0);
        ret_req = 1'b1;
        step();
        ret_req = 1'b0;
        checkStrobes("mid_ret_pop", 0, 1, 0, 1, 0);
        reset = 1'b1;
        step();
        step();
        checkResetState("reset_mid");
        reset = 1'b0;
        ref_q.delete();
        ref_ovf = 1'b0;
        ref_udf = 1'b0;
        step();

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)
                applyStimulus("rnd_conf", 1, 1, LARGURA'($urandom), LARGURA'($urandom), 0);
            else if (kind <= 4)
                applyStimulus("rnd_call", 1, 0, LARGURA'($urandom), LARGURA'($urandom), 0);
            else if (kind <= 8)
                applyStimulus("rnd_ret", 0, 1, LARGURA'($urandom), LARGURA'($urandom), bit'($urandom_range(0, 1)));
            else
                applyStimulus("rnd_idle", 0, 0, LARGURA'($urandom), LARGURA'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
